fetch_branch_predictor: RTL and testbench

//  Fetch-side counterpart of the execute-stage branch comparator. It owns the PC

---
 rtl/fetch_branch_predictor_if.sv | 27 ++
 rtl/fetch_branch_predictor.sv | 134 +++++++++++++
 tb/tb_fetch_branch_predictor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_branch_predictor_if.sv
// Fetch request and branch-resolve bundle between the fetch predictor and its neighbours.
// The master side is the predictor; the slave side is the imem plus the execute stage.
interface fetch_branch_predictor_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  pred_taken;
    logic                  resolve_valid;
    logic [DATA_WIDTH-1:0] resolve_pc;
    logic                  resolve_taken;
    logic [DATA_WIDTH-1:0] resolve_target;
    logic                  resolve_pred_taken;

    modport master (
        output imem_req_valid, imem_addr, pred_taken,
        input  imem_req_ready, resolve_valid, resolve_pc, resolve_taken,
               resolve_target, resolve_pred_taken
    );

    modport slave (
        input  imem_req_valid, imem_addr, pred_taken,
        output imem_req_ready, resolve_valid, resolve_pc, resolve_taken,
               resolve_target, resolve_pred_taken
    );
endinterface

// File: rtl/fetch_branch_predictor.sv
// PC owner and fetch issuer with a direct-mapped BTB of 2-bit counters; trains on
// resolved branches and redirects/flushes the pipeline on a misprediction.
module fetch_branch_predictor #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           BTB_ENTRIES = 8
) (
    input  logic clk,
    input  logic rstN,
    input  logic stall,
    output logic flush,
    fetch_branch_predictor_if.master bus
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = DATA_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DATA_WIDTH-1:0] target;
        logic [1:0]            ctr;
    } btb_entry_t;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    btb_entry_t            btb_q [BTB_ENTRIES];
    btb_entry_t            btb_d [BTB_ENTRIES];

    logic [IDX_W-1:0]      lk_idx, rs_idx;
    logic [TAG_W-1:0]      lk_tag, rs_tag;
    logic                  lk_hit, rs_hit;
    logic                  mispredict;
    logic                  req_valid;
    logic                  accept;

    // Lookup on the current PC and on the resolving branch; both see pre-update contents
    assign lk_idx     = pc_q[IDX_W+1:2];
    assign lk_tag     = pc_q[DATA_WIDTH-1:IDX_W+2];
    assign rs_idx     = bus.resolve_pc[IDX_W+1:2];
    assign rs_tag     = bus.resolve_pc[DATA_WIDTH-1:IDX_W+2];
    assign lk_hit     = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
    assign rs_hit     = btb_q[rs_idx].valid && (btb_q[rs_idx].tag == rs_tag);
    assign mispredict = bus.resolve_valid && (bus.resolve_taken != bus.resolve_pred_taken);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.pred_taken     = lk_hit && btb_q[lk_idx].ctr[1];
    assign flush              = (state_q == ST_REDIRECT);

    // Next-state and next-PC; a redirect overrides any fetch accepted this cycle
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_valid = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH, ST_REDIRECT: begin
                req_valid = !stall;
                state_d   = ST_FETCH;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        accept = req_valid && bus.imem_req_ready;

        if (mispredict) begin
            state_d = ST_REDIRECT;
            pc_d    = bus.resolve_taken ? bus.resolve_target
                                        : bus.resolve_pc + DATA_WIDTH'(4);
        end else if (accept) begin
            pc_d = bus.pred_taken ? btb_q[lk_idx].target : pc_q + DATA_WIDTH'(4);
        end
    end

    // BTB training: saturating counter update on hit, allocate on taken miss
    always_comb begin
        for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            btb_d[i] = btb_q[i];
        end
        if (bus.resolve_valid) begin
            if (rs_hit) begin
                if (bus.resolve_taken && (btb_q[rs_idx].ctr != 2'b11)) begin
                    btb_d[rs_idx].ctr = btb_q[rs_idx].ctr + 2'd1;
                end else if (!bus.resolve_taken && (btb_q[rs_idx].ctr != 2'b00)) begin
                    btb_d[rs_idx].ctr = btb_q[rs_idx].ctr - 2'd1;
                end
            end else if (bus.resolve_taken) begin
                btb_d[rs_idx].valid  = 1'b1;
                btb_d[rs_idx].tag    = rs_tag;
                btb_d[rs_idx].target = bus.resolve_target;
                btb_d[rs_idx].ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= 2'b01;
            end
        end else begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= btb_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// Bench for fetch_branch_predictor: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_fetch_branch_predictor;

    logic clk;
    logic rstN;
    logic stall;
    logic flush;

    int n_vec;
    int n_err;

    fetch_branch_predictor_if #(.DATA_WIDTH(32)) bus ();

    fetch_branch_predictor #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0),
        .BTB_ENTRIES(8)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .stall(stall),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: word-address keyed direct-mapped table, counters as 0..3
    int          m_phase;        // 0 boot, 1 fetching, 2 just redirected
    logic [31:0] m_pc;
    bit          m_v   [8];
    logic [31:0] m_key [8];
    logic [31:0] m_tgt [8];
    int          m_ctr [8];

    always @(negedge clk) begin
        logic [31:0] e_addr;
        logic        e_valid, e_pred, e_flush, hit, mis, acc;
        int          i;
        #2;
        if (!rstN) begin
            m_phase = 0;
            m_pc    = 32'h0;
            for (int k = 0; k < 8; k++) begin
                m_v[k] = 1'b0; m_key[k] = '0; m_tgt[k] = '0; m_ctr[k] = 1;
            end
        end
        i       = int'((m_pc >> 2) % 8);
        hit     = m_v[i] && (m_key[i] == (m_pc >> 2));
        e_addr  = m_pc;
        e_pred  = hit && (m_ctr[i] >= 2);
        e_valid = (m_phase != 0) && !stall;
        e_flush = (m_phase == 2);
        check("valid", 32'(bus.imem_req_valid), 32'(e_valid));
        check("addr",  bus.imem_addr,           e_addr);
        check("pred",  32'(bus.pred_taken),     32'(e_pred));
        check("flush", 32'(flush),              32'(e_flush));
        if (rstN) begin
            mis = bus.resolve_valid && (bus.resolve_taken != bus.resolve_pred_taken);
            acc = e_valid && bus.imem_req_ready;
            if (mis)
                m_pc = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
            else if (acc)
                m_pc = e_pred ? m_tgt[i] : m_pc + 32'd4;
            m_phase = mis ? 2 : 1;
            if (bus.resolve_valid) begin
                int j;
                j = int'((bus.resolve_pc >> 2) % 8);
                if (m_v[j] && m_key[j] == (bus.resolve_pc >> 2))
                    m_ctr[j] = bus.resolve_taken ? ((m_ctr[j] < 3) ? m_ctr[j] + 1 : 3)
                                                 : ((m_ctr[j] > 0) ? m_ctr[j] - 1 : 0);
                else if (bus.resolve_taken) begin
                    m_v[j] = 1'b1; m_key[j] = bus.resolve_pc >> 2;
                    m_tgt[j] = bus.resolve_target; m_ctr[j] = 2;
                end
            end
        end
    end

    // One cycle of stimulus, driven on the falling edge; returns after the model check
    task automatic cyc(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic [31:0] rtgt, input logic rpp);
        @(negedge clk);
        bus.imem_req_ready     = rdy;
        stall                  = stl;
        bus.resolve_valid      = rv;
        bus.resolve_pc         = rpc;
        bus.resolve_taken      = rt;
        bus.resolve_target     = rtgt;
        bus.resolve_pred_taken = rpp;
        #3;
    endtask

    task automatic idle(input logic rdy, input logic stl);
        cyc(rdy, stl, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstN  = 1'b0;
        stall = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.resolve_valid = 1'b0; bus.resolve_pc = '0; bus.resolve_taken = 1'b0;
        bus.resolve_target = '0;  bus.resolve_pred_taken = 1'b0;
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("rst_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_addr",  bus.imem_addr,           32'h0);

        // Sequential fetch after release: one BOOT cycle, then 0,4,8,...
        @(negedge clk); rstN = 1'b1; #3;
        check("boot_valid", 32'(bus.imem_req_valid), 32'd0);
        idle(1'b1, 1'b0); check("seq0", bus.imem_addr, 32'h0);
        check("seq0_valid", 32'(bus.imem_req_valid), 32'd1);
        idle(1'b1, 1'b0); check("seq1", bus.imem_addr, 32'h4);
        idle(1'b1, 1'b0); check("seq2", bus.imem_addr, 32'h8);

        // Taken mispredict allocates 0x10 -> 0x40
        cyc(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
        idle(1'b1, 1'b0);
        check("redir_flush", 32'(flush), 32'd1);
        check("redir_addr",  bus.imem_addr, 32'h40);
        cyc(1'b1, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h0, 1'b1);
        idle(1'b1, 1'b0);
        check("hit_addr", bus.imem_addr, 32'h10);
        check("hit_pred", 32'(bus.pred_taken), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 1'b1);
        check("pred_next", bus.imem_addr, 32'h40);

        // Counter at 11, then two not-taken resolves walk it down to 01
        cyc(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h40, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h40, 1'b1);
        check("nt1_addr", bus.imem_addr, 32'h14);
        cyc(1'b1, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h0, 1'b1);
        check("nt2_addr",  bus.imem_addr, 32'h14);
        check("nt2_flush", 32'(flush), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("weak_addr", bus.imem_addr, 32'h10);
        check("weak_pred", 32'(bus.pred_taken), 32'd0);

        // Back-pressure holds the request; a redirect replaces it
        cyc(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0);
        check("hold_addr", bus.imem_addr, 32'h10);
        check("hold_valid", 32'(bus.imem_req_valid), 32'd1);
        idle(1'b0, 1'b0);
        check("bp_redir_addr",  bus.imem_addr, 32'h80);
        check("bp_redir_flush", 32'(flush), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 1'b1);
        check("bp_hold2", bus.imem_addr, 32'h80);
        check("stall_valid", 32'(bus.imem_req_valid), 32'd0);

        // Redirect under stall, then resume at the corrected PC
        idle(1'b1, 1'b1);
        check("stall_addr",  bus.imem_addr, 32'h34);
        check("stall_flush", 32'(flush), 32'd1);
        check("stall_valid2", 32'(bus.imem_req_valid), 32'd0);
        idle(1'b1, 1'b0);
        check("resume_addr", bus.imem_addr, 32'h34);
        check("resume_valid", 32'(bus.imem_req_valid), 32'd1);

        // PC+4 wraps past the top of the address space
        cyc(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle(1'b1, 1'b0);
        check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b1, 32'hFC, 1'b0, 32'h0, 1'b1);
        check("wrap_addr", bus.imem_addr, 32'h0);
        idle(1'b1, 1'b0);
        check("pend_addr", bus.imem_addr, 32'h100);
        check("pend_pred", 32'(bus.pred_taken), 32'd1);

        // Mid-stream reset with a hit pending clears PC and BTB
        @(negedge clk); rstN = 1'b0; #3;
        check("mrst_addr",  bus.imem_addr, 32'h0);
        check("mrst_pred",  32'(bus.pred_taken), 32'd0);
        check("mrst_valid", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk); rstN = 1'b1; #3;
        cyc(1'b1, 1'b0, 1'b1, 32'hFC, 1'b0, 32'h0, 1'b1);
        idle(1'b1, 1'b0);
        check("post_rst_addr", bus.imem_addr, 32'h100);
        check("post_rst_pred", 32'(bus.pred_taken), 32'd0);

        // Random traffic over a small address window so entries alias and hit
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rstN                   = ($urandom_range(0, 399) != 0);
            bus.imem_req_ready     = ($urandom_range(0, 3) != 0);
            stall                  = ($urandom_range(0, 6) == 0);
            bus.resolve_valid      = ($urandom_range(0, 2) == 0);
            bus.resolve_pc         = 32'($urandom_range(0, 63)) << 2;
            bus.resolve_taken      = 1'($urandom_range(0, 1));
            bus.resolve_target     = 32'($urandom_range(0, 63)) << 2;
            bus.resolve_pred_taken = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rstN = 1'b1; bus.resolve_valid = 1'b0; stall = 1'b0;
        #5;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
